// File: rtl/dcp_arb_unit_if.sv
// Stream bundle for dcp_arb_unit: ANUM flattened input lanes merged into one output lane.
// The slave modport is the arbiter's view and the master modport is the traffic source/sink view.
`default_nettype none

interface dcp_arb_unit_if #(
    parameter int DW   = 8,
    parameter int AW   = 4,
    parameter int ANUM = 4,
    parameter int SW   = $clog2(ANUM)
);
    logic [ANUM-1:0]    iVld;
    logic [ANUM*DW-1:0] iPld;
    logic [ANUM*AW-1:0] iDst;
    logic [ANUM-1:0]    iLast;
    logic [ANUM-1:0]    oRdy;
    logic               oVld;
    logic [DW-1:0]      oPld;
    logic [AW-1:0]      oDst;
    logic               oLast;
    logic [SW-1:0]      oSrc;
    logic               iRdyOut;

    modport slave (
        input  iVld, iPld, iDst, iLast, iRdyOut,
        output oRdy, oVld, oPld, oDst, oLast, oSrc
    );

    modport master (
        output iVld, iPld, iDst, iLast, iRdyOut,
        input  oRdy, oVld, oPld, oDst, oLast, oSrc
    );
endinterface

`default_nettype wire

// File: rtl/dcp_arb_unit.sv
// dcp_arb_unit: round-robin N-to-1 stream merge with an optional per-packet grant lock
// and a single registered output stage.
`default_nettype none

module dcp_arb_unit #(
    parameter int DW   = 8,
    parameter int AW   = 4,
    parameter int ANUM = 4,
    parameter int LOCK = 1,
    parameter int SW   = $clog2(ANUM)
) (
    input  wire logic      iClk,
    input  wire logic      iRst_n,
    dcp_arb_unit_if.slave  bus
);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   lsrc_q,  lsrc_d;
    logic [SW-1:0]   ptr_q,   ptr_d;
    logic            vld_q,   vld_d;
    logic [DW-1:0]   pld_q,   pld_d;
    logic [AW-1:0]   dst_q,   dst_d;
    logic            last_q,  last_d;
    logic [SW-1:0]   src_q,   src_d;

    logic            srch_hit;
    logic [SW-1:0]   srch_idx;
    logic            gnt_hit;
    logic [SW-1:0]   gnt_idx;
    logic            load;
    logic            accept;
    logic            sel_last;

    // Rotating search starting at ptr; the index wraps explicitly so ANUM need not be a power of two.
    always_comb begin
        logic [SW:0] cand;
        cand     = '0;
        srch_hit = 1'b0;
        srch_idx = '0;
        for (int k = 0; k < ANUM; k++) begin
            cand = {1'b0, ptr_q} + (SW+1)'(k);
            if (cand >= (SW+1)'(ANUM)) begin
                cand = cand - (SW+1)'(ANUM);
            end
            if (!srch_hit && bus.iVld[cand[SW-1:0]]) begin
                srch_hit = 1'b1;
                srch_idx = cand[SW-1:0];
            end
        end
    end

    // A locked source keeps the grant even while its valid is low mid-packet.
    assign gnt_hit  = (state_q == ST_LOCKED) ? 1'b1   : srch_hit;
    assign gnt_idx  = (state_q == ST_LOCKED) ? lsrc_q : srch_idx;
    assign load     = ~vld_q | bus.iRdyOut;
    assign accept   = load & gnt_hit & bus.iVld[gnt_idx];
    assign sel_last = bus.iLast[gnt_idx];

    assign bus.oRdy = (load && gnt_hit && iRst_n) ? (ANUM'(1) << gnt_idx) : '0;

    always_comb begin
        state_d = state_q;
        lsrc_d  = lsrc_q;
        ptr_d   = ptr_q;
        vld_d   = vld_q;
        pld_d   = pld_q;
        dst_d   = dst_q;
        last_d  = last_q;
        src_d   = src_q;
        if (accept) begin
            vld_d  = 1'b1;
            pld_d  = bus.iPld[gnt_idx*DW +: DW];
            dst_d  = bus.iDst[gnt_idx*AW +: AW];
            last_d = sel_last;
            src_d  = gnt_idx;
            ptr_d  = (gnt_idx == SW'(ANUM-1)) ? '0 : gnt_idx + SW'(1);
            if (LOCK != 0) begin
                case (state_q)
                    ST_IDLE: begin
                        if (!sel_last) begin
                            state_d = ST_LOCKED;
                            lsrc_d  = gnt_idx;
                        end
                    end
                    ST_LOCKED: begin
                        if (sel_last) begin
                            state_d = ST_IDLE;
                        end
                    end
                    default: state_d = ST_IDLE;
                endcase
            end
        end else if (load) begin
            vld_d = 1'b0;
        end
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q <= ST_IDLE;
            lsrc_q  <= '0;
            ptr_q   <= '0;
            vld_q   <= 1'b0;
            pld_q   <= '0;
            dst_q   <= '0;
            last_q  <= 1'b0;
            src_q   <= '0;
        end else begin
            state_q <= state_d;
            lsrc_q  <= lsrc_d;
            ptr_q   <= ptr_d;
            vld_q   <= vld_d;
            pld_q   <= pld_d;
            dst_q   <= dst_d;
            last_q  <= last_d;
            src_q   <= src_d;
        end
    end

    assign bus.oVld  = vld_q;
    assign bus.oPld  = pld_q;
    assign bus.oDst  = dst_q;
    assign bus.oLast = last_q;
    assign bus.oSrc  = src_q;

endmodule

`default_nettype wire

// File: tb/tb_dcp_arb_unit.sv
// Scoreboard bench for dcp_arb_unit: per-source beat queues, a reference arbitration model
// predicting oRdy/oVld each cycle, and an in-order queue of expected output beats.
`default_nettype none

module tb_dcp_arb_unit;
    localparam int DW   = 8;
    localparam int AW   = 4;
    localparam int ANUM = 4;
    localparam int SW   = 2;

    typedef struct packed {
        logic [DW-1:0] pld;
        logic [AW-1:0] dst;
        logic          last;
    } beat_t;

    typedef struct packed {
        beat_t         b;
        logic [SW-1:0] src;
    } exp_t;

    logic iClk = 1'b0;
    logic iRst_n = 1'b0;

    dcp_arb_unit_if #(.DW(DW), .AW(AW), .ANUM(ANUM), .SW(SW)) bus ();

    dcp_arb_unit #(.DW(DW), .AW(AW), .ANUM(ANUM), .LOCK(1), .SW(SW)) dut (
        .iClk   (iClk),
        .iRst_n (iRst_n),
        .bus    (bus)
    );

    always #5 iClk = ~iClk;

    beat_t srcq [ANUM][$];
    exp_t  sbq [$];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int rmode = 0;

    // reference model state
    logic          m_ovld = 1'b0;
    logic          m_lock = 1'b0;
    logic [SW-1:0] m_lsrc = '0;
    logic [SW-1:0] m_ptr  = '0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic push_beat(input int s, input logic [DW-1:0] p, input logic [AW-1:0] d, input logic l);
        beat_t b;
        b.pld  = p;
        b.dst  = d;
        b.last = l;
        srcq[s].push_back(b);
    endtask

    function automatic int pending();
        int n = sbq.size();
        for (int i = 0; i < ANUM; i++) n += srcq[i].size();
        return n;
    endfunction

    task automatic drive_inputs(output logic [ANUM-1:0] v);
        logic [ANUM*DW-1:0] p;
        logic [ANUM*AW-1:0] d;
        logic [ANUM-1:0]    l;
        v = '0; p = '0; d = '0; l = '0;
        for (int i = 0; i < ANUM; i++) begin
            if (srcq[i].size() > 0) begin
                v[i]          = 1'b1;
                p[i*DW +: DW] = srcq[i][0].pld;
                d[i*AW +: AW] = srcq[i][0].dst;
                l[i]          = srcq[i][0].last;
            end
        end
        bus.iVld  = v;
        bus.iPld  = p;
        bus.iDst  = d;
        bus.iLast = l;
    endtask

    // One clock: drive at negedge, check just after, advance the model for the coming posedge.
    task automatic cycle();
        logic [ANUM-1:0] v;
        logic            rdy, mload, mhave, macc;
        logic [SW-1:0]   mg;
        logic [ANUM-1:0] exp_rdy;
        exp_t            e;
        beat_t           b;
        @(negedge iClk);
        cyc++;
        drive_inputs(v);
        case (rmode)
            0:       rdy = 1'b1;
            1:       rdy = ((cyc / 2) % 2) == 1;
            default: rdy = 1'b0;
        endcase
        bus.iRdyOut = rdy;
        #1;
        mload = !m_ovld || rdy;
        mhave = 1'b0;
        mg    = '0;
        if (m_lock) begin
            mhave = 1'b1;
            mg    = m_lsrc;
        end else begin
            for (int k = 0; k < ANUM; k++) begin
                int idx;
                idx = (int'(m_ptr) + k) % ANUM;
                if (!mhave && v[idx]) begin
                    mhave = 1'b1;
                    mg    = SW'(idx);
                end
            end
        end
        exp_rdy = (mload && mhave) ? (ANUM'(1) << mg) : '0;
        check_eq("oRdy", 32'(bus.oRdy), 32'(exp_rdy));
        check_eq("oVld", 32'(bus.oVld), 32'(m_ovld));
        if (m_ovld) begin
            if (sbq.size() == 0) begin
                check_eq("sb_underflow", 32'(sbq.size()), 32'd1);
            end else begin
                e = sbq[0];
                check_eq("oPld",  32'(bus.oPld),  32'(e.b.pld));
                check_eq("oDst",  32'(bus.oDst),  32'(e.b.dst));
                check_eq("oLast", 32'(bus.oLast), 32'(e.b.last));
                check_eq("oSrc",  32'(bus.oSrc),  32'(e.src));
                if (rdy) void'(sbq.pop_front());
            end
        end
        macc = mload && mhave && v[mg];
        if (macc) begin
            b = srcq[mg].pop_front();
            e.b   = b;
            e.src = mg;
            sbq.push_back(e);
            m_ptr = (mg == SW'(ANUM-1)) ? '0 : mg + SW'(1);
            if (!m_lock && !b.last) begin
                m_lock = 1'b1;
                m_lsrc = mg;
            end else if (m_lock && b.last) begin
                m_lock = 1'b0;
            end
            m_ovld = 1'b1;
        end else if (mload) begin
            m_ovld = 1'b0;
        end
    endtask

    task automatic drain(input int budget);
        for (int c = 0; c < budget; c++) begin
            if (pending() == 0) break;
            cycle();
        end
        check_eq("drain", 32'(pending()), 32'd0);
        cycle();
    endtask

    task automatic model_reset();
        m_ovld = 1'b0;
        m_lock = 1'b0;
        m_lsrc = '0;
        m_ptr  = '0;
        sbq.delete();
        for (int i = 0; i < ANUM; i++) srcq[i].delete();
    endtask

    initial begin
        logic [ANUM-1:0] v;
        int reached;
        bus.iVld = '0; bus.iPld = '0; bus.iDst = '0; bus.iLast = '0; bus.iRdyOut = 1'b1;

        // reset state with all inputs requesting
        for (int i = 0; i < ANUM; i++) push_beat(i, 8'h30 + 8'(i), 4'(i), 1'b1);
        drive_inputs(v);
        #12;
        check_eq("rst_oRdy", 32'(bus.oRdy), 32'd0);
        check_eq("rst_oVld", 32'(bus.oVld), 32'd0);
        check_eq("rst_oPld", 32'(bus.oPld), 32'd0);
        check_eq("rst_oSrc", 32'(bus.oSrc), 32'd0);
        model_reset();
        drive_inputs(v);
        @(negedge iClk);
        iRst_n = 1'b1;

        // single source, 3-beat packet on input 2
        push_beat(2, 8'h11, 4'h5, 1'b0);
        push_beat(2, 8'h12, 4'h6, 1'b0);
        push_beat(2, 8'h13, 4'h7, 1'b1);
        drain(20);

        // round-robin, every input continuously valid with single-beat packets
        for (int r = 0; r < 3; r++)
            for (int i = 0; i < ANUM; i++) push_beat(i, 8'(i), 4'(r), 1'b1);
        drain(40);

        // packet lock: input 1 sends A0..A2 while input 0 stays valid
        for (int r = 0; r < 3; r++) push_beat(0, 8'h50 + 8'(r), 4'h0, 1'b1);
        push_beat(1, 8'hA0, 4'h1, 1'b0);
        push_beat(1, 8'hA1, 4'h1, 1'b0);
        push_beat(1, 8'hA2, 4'h1, 1'b1);
        drain(30);

        // backpressure: iRdyOut toggles every 2 cycles, 16 beats across inputs 0..3
        rmode = 1;
        for (int n = 0; n < 16; n++) push_beat(n % ANUM, 8'h40 + 8'(n), 4'(n), 1'b1);
        drain(120);
        rmode = 0;

        // downstream stall, then release with no bubble
        push_beat(1, 8'hC1, 4'h9, 1'b1);
        push_beat(2, 8'hC2, 4'hA, 1'b1);
        push_beat(3, 8'hC3, 4'hB, 1'b1);
        cycle();
        rmode = 2;
        repeat (3) cycle();
        rmode = 0;
        drain(20);

        // reset mid-packet while locked on input 3
        for (int r = 0; r < 5; r++) push_beat(3, 8'hB0 + 8'(r), 4'h3, r == 4);
        push_beat(0, 8'hD0, 4'h0, 1'b1);
        push_beat(1, 8'hD1, 4'h1, 1'b1);
        reached = 0;
        for (int c = 0; c < 20; c++) begin
            cycle();
            if (m_lock && m_lsrc == 2'd3) begin
                reached = 1;
                break;
            end
        end
        check_eq("lock3_wait", 32'(reached), 32'd1);
        @(posedge iClk);
        #2;
        iRst_n = 1'b0;
        #1;
        check_eq("midrst_oVld", 32'(bus.oVld), 32'd0);
        check_eq("midrst_oRdy", 32'(bus.oRdy), 32'd0);
        model_reset();
        drive_inputs(v);
        repeat (2) @(negedge iClk);
        iRst_n = 1'b1;
        for (int i = ANUM - 1; i >= 0; i--) push_beat(i, 8'hE0 + 8'(i), 4'(i), 1'b1);
        drain(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
